// File: rtl/ping_trigger_if.sv
// Sample/FIFO-control bundle between the ADC driver, the sample FIFO and ping_trigger.
// slave is the trigger's view; master is the view of whoever drives samples and FIFO flags.
interface ping_trigger_if;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        fifo_full;
    logic        fifo_empty;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] data_out;
    logic        triggered;
    logic        capture_done;

    modport slave (
        input  sample_in, sample_valid, fifo_full, fifo_empty,
        output mem_write, mem_read, data_out, triggered, capture_done
    );

    modport master (
        output sample_in, sample_valid, fifo_full, fifo_empty,
        input  mem_write, mem_read, data_out, triggered, capture_done
    );
endinterface

// File: rtl/ping_trigger.sv
// Ping trigger: keeps a rolling pre-trigger window in an external FIFO, fires on a run of
// strong samples, then writes a fixed-length post-trigger capture and waits for readout.
module ping_trigger #(
    parameter logic [15:0] THRESHOLD          = 16'd32,
    parameter logic [7:0]  VALID_COUNT_NEEDED = 8'd4,
    parameter logic [13:0] PRETRIG_LEN        = 14'd10,
    parameter logic [13:0] CAPTURE_LEN        = 14'd20
) (
    input  logic          clk,
    input  logic          rst,
    ping_trigger_if.slave bus
);

    typedef enum logic [1:0] {FILL, CAPTURE, DONE} state_t;

    state_t      state_reg, state_next;
    logic [13:0] pre_cnt_reg, pre_cnt_next;
    logic [7:0]  run_cnt_reg, run_cnt_next;
    logic [13:0] cap_cnt_reg, cap_cnt_next;
    logic        mem_write_reg, mem_write_next;
    logic        mem_read_reg, mem_read_next;
    logic [15:0] data_out_reg, data_out_next;
    logic        triggered_reg, triggered_next;
    logic        capture_done_reg, capture_done_next;

    logic [15:0] magnitude;
    logic        over;
    logic [7:0]  run_inc;
    logic [13:0] cap_inc;

    // -32768 has no positive counterpart, so it saturates to the largest magnitude.
    always_comb begin
        if (!bus.sample_in[15])
            magnitude = bus.sample_in;
        else if (bus.sample_in == 16'h8000)
            magnitude = 16'h7FFF;
        else
            magnitude = ~bus.sample_in + 16'd1;
    end

    assign over    = (magnitude >= THRESHOLD);
    assign run_inc = run_cnt_reg + 8'd1;
    assign cap_inc = cap_cnt_reg + 14'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= FILL;
            pre_cnt_reg      <= '0;
            run_cnt_reg      <= '0;
            cap_cnt_reg      <= '0;
            mem_write_reg    <= 1'b0;
            mem_read_reg     <= 1'b0;
            data_out_reg     <= 16'h0000;
            triggered_reg    <= 1'b0;
            capture_done_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            pre_cnt_reg      <= pre_cnt_next;
            run_cnt_reg      <= run_cnt_next;
            cap_cnt_reg      <= cap_cnt_next;
            mem_write_reg    <= mem_write_next;
            mem_read_reg     <= mem_read_next;
            data_out_reg     <= data_out_next;
            triggered_reg    <= triggered_next;
            capture_done_reg <= capture_done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pre_cnt_next   = pre_cnt_reg;
        run_cnt_next   = run_cnt_reg;
        cap_cnt_next   = cap_cnt_reg;
        mem_write_next = 1'b0;
        mem_read_next  = 1'b0;
        data_out_next  = data_out_reg;

        case (state_reg)
            FILL: begin
                if (bus.sample_valid) begin
                    mem_write_next = 1'b1;
                    data_out_next  = bus.sample_in;
                    // Drop the oldest sample once the window is full, or whenever the FIFO says so.
                    mem_read_next  = (pre_cnt_reg == PRETRIG_LEN) || bus.fifo_full;
                    if (pre_cnt_reg != PRETRIG_LEN)
                        pre_cnt_next = pre_cnt_reg + 14'd1;
                    if (over) begin
                        if (run_inc == VALID_COUNT_NEEDED) begin
                            state_next   = (CAPTURE_LEN <= 14'd1) ? DONE : CAPTURE;
                            cap_cnt_next = 14'd1;
                            run_cnt_next = '0;
                        end else begin
                            run_cnt_next = run_inc;
                        end
                    end else begin
                        run_cnt_next = '0;
                    end
                end
            end
            CAPTURE: begin
                // A full FIFO ends the capture early and suppresses the concurrent write.
                if (bus.fifo_full) begin
                    state_next = DONE;
                end else if (bus.sample_valid) begin
                    mem_write_next = 1'b1;
                    data_out_next  = bus.sample_in;
                    cap_cnt_next   = cap_inc;
                    if (cap_inc >= CAPTURE_LEN)
                        state_next = DONE;
                end
            end
            DONE: begin
                if (bus.fifo_empty) begin
                    state_next   = FILL;
                    pre_cnt_next = '0;
                    run_cnt_next = '0;
                    cap_cnt_next = '0;
                end
            end
            default: state_next = FILL;
        endcase

        triggered_next    = (state_next != FILL);
        capture_done_next = (state_next == DONE);
    end

    assign bus.mem_write    = mem_write_reg;
    assign bus.mem_read     = mem_read_reg;
    assign bus.data_out     = data_out_reg;
    assign bus.triggered    = triggered_reg;
    assign bus.capture_done = capture_done_reg;

endmodule

// File: tb/tb_ping_trigger.sv
// Self-checking bench for ping_trigger: expected FIFO strobes go into a scoreboard queue
// and a forked monitor pops and compares them whenever the DUT strobes the FIFO.
module tb_ping_trigger;

    logic clk;
    logic rst;

    ping_trigger_if bus0();
    ping_trigger_if bus1();

    ping_trigger dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    // Second instance isolates the -32768 saturation case at the top of the range.
    ping_trigger #(
        .THRESHOLD          (16'h7FFF),
        .VALID_COUNT_NEEDED (8'd1)
    ) dut_edge (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    logic [16:0] sb[$];   // {expected mem_read, expected data_out}; mem_write always expected

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one strobe; returns 1 time unit after the edge that registered it.
    task automatic send(input logic [15:0] s, input logic exp_rd, input logic exp_wr);
        bus0.sample_in    = s;
        bus0.sample_valid = 1'b1;
        if (exp_wr)
            sb.push_back({exp_rd, s});
        @(posedge clk);
        #1 bus0.sample_valid = 1'b0;
    endtask

    task automatic empty_pulse();
        bus0.fifo_empty = 1'b1;
        @(posedge clk);
        #1 bus0.fifo_empty = 1'b0;
        check("rearm_triggered", {31'd0, bus0.triggered}, 32'd0);
        check("rearm_capture_done", {31'd0, bus0.capture_done}, 32'd0);
    endtask

    task automatic monitor();
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (bus0.mem_write || bus0.mem_read) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got wr=%0b rd=%0b data=%h, expected no strobe",
                             bus0.mem_write, bus0.mem_read, bus0.data_out);
                end else begin
                    e = sb.pop_front();
                    check("strobe", {14'd0, bus0.mem_write, bus0.mem_read, bus0.data_out},
                          {14'd0, 1'b1, e});
                    $display("txn wr=%0b rd=%0b data=%h", bus0.mem_write, bus0.mem_read, bus0.data_out);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus0.sample_in = '0; bus0.sample_valid = 1'b0; bus0.fifo_full = 1'b0; bus0.fifo_empty = 1'b0;
        bus1.sample_in = '0; bus1.sample_valid = 1'b0; bus1.fifo_full = 1'b0; bus1.fifo_empty = 1'b0;

        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {11'd0, bus0.mem_write, bus0.mem_read, bus0.data_out,
                                bus0.triggered, bus0.capture_done}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Saturated magnitude: 0x7FFE is below 0x7FFF, 0x8000 saturates to 0x7FFF and fires.
        bus1.sample_in = 16'h7FFE; bus1.sample_valid = 1'b1;
        @(posedge clk);
        #1 bus1.sample_valid = 1'b0;
        check("edge_7ffe_not_over", {31'd0, bus1.triggered}, 32'd0);
        bus1.sample_in = 16'h8000; bus1.sample_valid = 1'b1;
        @(posedge clk);
        #1 bus1.sample_valid = 1'b0;
        check("edge_8000_over", {31'd0, bus1.triggered}, 32'd1);

        // Pre-trigger wrap: reads start on sample 11.
        for (int i = 1; i <= 15; i++)
            send(16'd5, (i > 10), 1'b1);
        check("wrap_triggered", {31'd0, bus0.triggered}, 32'd0);

        // Trigger on 40, -40, 33, 32 with the window full.
        send(16'd40, 1'b1, 1'b1);
        send(16'hFFD8, 1'b1, 1'b1);
        send(16'd33, 1'b1, 1'b1);
        check("trig_before_4th", {31'd0, bus0.triggered}, 32'd0);
        send(16'd32, 1'b1, 1'b1);
        check("trig_after_4th", {31'd0, bus0.triggered}, 32'd1);
        check("trig_not_done", {31'd0, bus0.capture_done}, 32'd0);

        // Capture samples 2..20, no reads.
        for (int i = 1; i <= 19; i++) begin
            send(16'(100 + i), 1'b0, 1'b1);
            if (i == 18)
                check("cap19_not_done", {31'd0, bus0.capture_done}, 32'd0);
        end
        check("cap20_done", {31'd0, bus0.capture_done}, 32'd1);

        // Samples in DONE are ignored.
        for (int i = 0; i < 3; i++)
            send(16'd200, 1'b0, 1'b0);
        check("done_holds", {31'd0, bus0.capture_done}, 32'd1);
        empty_pulse();

        // Broken run: the low sample restarts the count.
        send(16'd40, 1'b0, 1'b1);
        send(16'd40, 1'b0, 1'b1);
        send(16'd40, 1'b0, 1'b1);
        send(16'd10, 1'b0, 1'b1);
        send(16'd40, 1'b0, 1'b1);
        send(16'd40, 1'b0, 1'b1);
        send(16'd40, 1'b0, 1'b1);
        check("broken_run_7th", {31'd0, bus0.triggered}, 32'd0);
        send(16'd40, 1'b0, 1'b1);
        check("broken_run_8th", {31'd0, bus0.triggered}, 32'd1);

        // FIFO full mid-capture: no write, straight to DONE.
        send(16'd300, 1'b0, 1'b1);
        send(16'd301, 1'b0, 1'b1);
        bus0.fifo_full = 1'b1;
        send(16'd302, 1'b0, 1'b0);
        bus0.fifo_full = 1'b0;
        check("full_done", {31'd0, bus0.capture_done}, 32'd1);
        check("full_triggered", {31'd0, bus0.triggered}, 32'd1);
        empty_pulse();

        // Reset mid-capture at cap_cnt = 7.
        for (int i = 0; i < 4; i++)
            send(16'd64, 1'b0, 1'b1);
        check("rst_trig", {31'd0, bus0.triggered}, 32'd1);
        for (int i = 0; i < 6; i++)
            send(16'(400 + i), 1'b0, 1'b1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("midcap_reset_outputs", {11'd0, bus0.mem_write, bus0.mem_read, bus0.data_out,
                                       bus0.triggered, bus0.capture_done}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            send(16'd50, 1'b0, 1'b1);
        check("post_rst_3rd", {31'd0, bus0.triggered}, 32'd0);
        send(16'd50, 1'b0, 1'b1);
        check("post_rst_4th", {31'd0, bus0.triggered}, 32'd1);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
